// File: rtl/instruction_decoder.sv
// rtl/instruction_decoder.sv - V850 front end: halfword fetch, decode, operand read, branch redirect
module instruction_decoder #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [15:0] imem_data_i,
  input  logic [31:0] GR_i [31:0],
  input  logic [31:0] PSW_i,
  input  logic [31:0] PC_i,
  output logic [4:0]  destination_o,
  output logic [31:0] reg1_o,
  output logic [31:0] reg2_o,
  output logic        increment_bit_o,
  output logic [4:0]  circuit_sel_o,
  output logic        illegal_o
);

  typedef enum logic [1:0] {FETCH0, FETCH1, ISSUE, REDIRECT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q;
  logic [15:0] hw0_q;
  logic        taken_q, len4_q;

  logic [15:0] hw0, hw1;
  logic        is_long0, final_ack;
  logic [31:0] gr1, gr2, disp;
  logic [4:0]  d_sel, d_dest;
  logic [31:0] d_reg1, d_reg2;
  logic        d_ill, d_taken, d_len4, cond_ok;
  logic        unused_bits;

  assign unused_bits     = ^{PC_i[0], PSW_i[31:2]};
  assign increment_bit_o = 1'b0;

  assign is_long0  = (imem_data_i[10:8] == 3'b110) || (imem_data_i[10:5] == 6'b111111);
  assign final_ack = imem_ack_i && ((state == FETCH0 && !is_long0) || state == FETCH1);
  assign hw0       = (state == FETCH1) ? hw0_q : imem_data_i;
  assign hw1       = imem_data_i;
  assign gr1       = (hw0[4:0] == 5'd0) ? 32'h0 : GR_i[hw0[4:0]];
  assign gr2       = (hw0[15:11] == 5'd0) ? 32'h0 : GR_i[hw0[15:11]];
  assign disp      = {{23{hw0[15]}}, hw0[15:11], hw0[6:4], 1'b0};

  always_comb begin
    case (hw0[3:0])
      4'b0101: cond_ok = 1'b1;
      4'b0010: cond_ok = PSW_i[0];
      4'b1010: cond_ok = !PSW_i[0];
      4'b0100: cond_ok = PSW_i[1];
      4'b1100: cond_ok = !PSW_i[1];
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    d_sel   = 5'd0;
    d_dest  = hw0[15:11];
    d_reg1  = gr1;
    d_reg2  = gr2;
    d_ill   = 1'b0;
    d_taken = 1'b0;
    d_len4  = 1'b0;
    if (state == FETCH1) begin
      d_len4 = 1'b1;
      if (hw0[10:5] == 6'b110000) begin
        d_sel  = 5'd1;
        d_reg2 = {{16{hw1[15]}}, hw1};
      end else if (hw0[10:5] == 6'b110110) begin
        d_sel  = 5'd2;
        d_reg2 = {16'h0, hw1};
      end else if (hw0[10:5] == 6'b110100) begin
        d_sel  = 5'd3;
        d_reg2 = {16'h0, hw1};
      end else if (hw0[10:0] == 11'b11111100000 && hw1[10:0] == 11'b01101000000) begin
        d_sel  = 5'd7;
        d_dest = hw1[15:11];
        d_reg1 = 32'h0;
        d_reg2 = {gr2[7:0], gr2[15:8], gr2[23:16], gr2[31:24]};
      end else if (hw0[10:0] == 11'b11111100000 && hw1[10:0] == 11'b01101000010) begin
        d_sel  = 5'd6;
        d_dest = hw1[15:11];
        d_reg1 = 32'h0;
        d_reg2 = {gr2[23:16], gr2[31:24], gr2[7:0], gr2[15:8]};
      end else begin
        d_ill  = 1'b1;
        d_len4 = 1'b0;
      end
    end else begin
      casez (hw0[10:5])
        6'b001110: d_sel = 5'd1;
        6'b001010: d_sel = 5'd2;
        6'b001000: d_sel = 5'd3;
        6'b010010: begin
          d_sel  = 5'd1;
          d_reg1 = {{27{hw0[4]}}, hw0[4:0]};
        end
        6'b1011??: begin
          if (cond_ok) begin
            d_sel   = 5'd1;
            d_taken = 1'b1;
            d_dest  = 5'd0;
            d_reg1  = pc_q;
            d_reg2  = disp;
          end
        end
        default: d_ill = 1'b1;
      endcase
    end
    // A write to r0 would alias the PC-write encoding, so it is dropped.
    if (d_dest == 5'd0 && !d_taken) d_sel = 5'd0;
    if (d_sel == 5'd0) begin
      d_dest = 5'd0;
      d_reg1 = 32'h0;
      d_reg2 = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH0;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH0:   if (imem_ack_i) state_nxt = is_long0 ? FETCH1 : ISSUE;
      FETCH1:   if (imem_ack_i) state_nxt = ISSUE;
      ISSUE:    state_nxt = taken_q ? REDIRECT : FETCH0;
      REDIRECT: state_nxt = FETCH0;
      default:  state_nxt = FETCH0;
    endcase
  end

  always_comb begin
    imem_req_o  = rst_n && (state == FETCH0 || state == FETCH1);
    imem_addr_o = (state == FETCH1) ? pc_q + 32'd2 : pc_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      hw0_q         <= 16'h0;
      taken_q       <= 1'b0;
      len4_q        <= 1'b0;
      circuit_sel_o <= 5'd0;
      destination_o <= 5'd0;
      reg1_o        <= 32'h0;
      reg2_o        <= 32'h0;
      illegal_o     <= 1'b0;
    end else begin
      circuit_sel_o <= 5'd0;
      destination_o <= 5'd0;
      reg1_o        <= 32'h0;
      reg2_o        <= 32'h0;
      illegal_o     <= 1'b0;
      if (state == FETCH0 && imem_ack_i && is_long0) hw0_q <= imem_data_i;
      if (final_ack) begin
        circuit_sel_o <= d_sel;
        destination_o <= d_dest;
        reg1_o        <= d_reg1;
        reg2_o        <= d_reg2;
        illegal_o     <= d_ill;
        taken_q       <= d_taken;
        len4_q        <= d_len4;
      end
      if (state == ISSUE && !taken_q) pc_q <= pc_q + (len4_q ? 32'd4 : 32'd2);
      if (state == REDIRECT)          pc_q <= {PC_i[31:1], 1'b0};
    end
  end

endmodule

// File: doc/instruction_decoder.md
# instruction_decoder

Front end of the V850 core: fetches 16-bit and 32-bit instructions from instruction memory over a req/ack halfword interface. Each instruction is decoded into the executer's operand bundle (`destination`, `reg1`, `reg2`, `increment_bit`, `circuit_sel`), with register operands read from the executer's `GR`. The block is non-pipelined: one instruction is in flight, and the decoder owns the sequential fetch pointer. On a taken branch it reloads the fetch pointer from the executer's `PC`.

## Interface

**Parameters**

- `RESET_PC`, default 32'h0000_0000: fetch address after reset.

**Ports**

- Clock and reset are decided: one clock, `clk`; reset is synchronous and active-low, `rst_n`.
- `clk` in 1: clock; all state updates on the posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `imem_req_o` out 1: fetch request.
- `imem_addr_o` out 32: halfword address; bit 0 is always 0.
- `imem_ack_i` in 1: `imem_data_i` is valid this cycle.
- `imem_data_i` in 16: instruction halfword.
- `GR_i` in 32x32 (unpacked [31:0]): executer register file.
- `PSW_i` in 32: executer PSW; bit 1 = S, bit 0 = Z.
- `PC_i` in 32: executer PC, written only by taken branches.
- `destination_o` out 5: destination register; 0 means write PC.
- `reg1_o` out 32: operand 1.
- `reg2_o` out 32: operand 2.
- `increment_bit_o` out 1: carry-in; always 0 for the current instruction subset.
- `circuit_sel_o` out 5: executer function; 0 = no operation.
- `illegal_o` out 1: one-cycle pulse for an undecodable instruction.

## Operation

**States:** FETCH0, FETCH1, ISSUE, REDIRECT.

**FETCH0**
- `imem_req_o`=1 with `imem_addr_o`=pc.
- On ack:
  - If hw0[10:5] is 110xxx or 111111: capture hw0 and go to FETCH1.
  - Otherwise: decode and go to ISSUE.

**FETCH1**
- `imem_req_o`=1 with `imem_addr_o`=pc+2.
- On ack: decode {hw0, hw1} and go to ISSUE.

**Request/address rule:** `imem_req_o` and `imem_addr_o` stay stable until ack.

**Operand reads**
- Register fields r1=hw0[4:0] and r2=hw0[15:11] are read from `GR_i` in the ack cycle.
- Field value 0 reads as 32'h0 regardless of `GR_i`.

**Decode (sel, dest, reg1_o, reg2_o)**
- ADD reg1,reg2 (hw0[10:5]=001110): 00001, dest r2, GR[r1], GR[r2].
- AND (001010): 00010, same operand mapping.
- OR (001000): 00011, same operand mapping.
- ADD imm5 (010010): 00001, dest r2, sext(hw0[4:0]), GR[r2].
- ADDI (110000): 00001, dest r2, GR[r1], sext(hw1).
- ANDI (110110): 00010, dest r2, GR[r1], zext(hw1).
- ORI (110100): 00011, dest r2, GR[r1], zext(hw1).
- BSW (hw0[10:0]=11111100000, hw1[10:0]=01101000000): 00111, dest hw1[15:11], 0, byte-reversed GR[r2].
- BSH (hw1[10:0]=01101000010): 00110, dest hw1[15:11], 0, GR[r2] with bytes swapped within each halfword.
- Bcond (hw0[10:7]=1011):
  - disp = sext({hw0[15:11], hw0[6:4], 1'b0}), 9-bit.
  - cond hw0[3:0]: 0101 always, 0010 Z=1, 1010 Z=0, 0100 S=1, 1100 S=0.
  - Taken: 00001, dest 0, pc, disp.
  - Not taken: sel 0.
- Any other 16-bit pattern, or a 32-bit pattern not listed: sel 0, `illegal_o`=1 for the ISSUE cycle, length 2.

**Write suppression:** any ALU or BSx result with dest=0 is issued as sel 0. This prevents a spurious PC write; r0 is hardwired to zero.

**ISSUE**
- Outputs are registered at the final-ack edge.
- `circuit_sel_o` is nonzero only during ISSUE.
- Next state:
  - Taken branch: REDIRECT.
  - Otherwise: pc += 2 (16-bit) or 4 (32-bit), then FETCH0.
- pc arithmetic is modulo 2^32; it wraps at 32'hFFFF_FFFE.

**REDIRECT:** pc <= {`PC_i`[31:1], 1'b0}, then FETCH0.

## Timing

**Reset state** (`rst_n`=0 at a posedge):
- FETCH0 with pc=`RESET_PC`, but `imem_req_o`=0 during the reset cycle.
- All data outputs 0; `circuit_sel_o`=0; `illegal_o`=0.

**Reset during FETCH1 or ISSUE:** the partial instruction is discarded, `imem_req_o` drops in the next cycle, and nothing is issued.

**Acknowledge timing:** ack may arrive in the same cycle as the request.
- Minimum 16-bit instruction: 2 cycles (FETCH0, ISSUE).
- Minimum 32-bit instruction: 3 cycles.
- Minimum taken branch: 3 cycles.

**GR/PSW hazard:** GR and PSW writes by the executer land at the ISSUE→next edge. The next instruction's operand read and the Bcond PSW sample occur at FETCH0 or later, so there is no hazard and no bypass.

**Ack outside FETCH0/FETCH1:** ignored.

## Test plan

1. **Reset:** `rst_n`=0 for 2 cycles, then 1 → `imem_req_o`=0 during reset, then 1 with `imem_addr_o`=0x0; `circuit_sel_o`=0 throughout.
2. **ADD:** hw 0x11C1 with GR[1]=5, GR[2]=7 → ISSUE shows sel 00001, dest 2, reg1_o 5, reg2_o 7, `increment_bit_o` 0; next fetch at 0x2.
3. **ADDI:** 0x2603 then 0xFFFF with GR[3]=1 → sel 00001, dest 4, reg1_o 1, reg2_o 0xFFFFFFFF; next fetch at pc+4. Then stall ack 3 cycles in FETCH1 → address is held at pc+2 throughout.
4. **BSW:** 0x2FE0, 0x3340 with GR[5]=0x11223344 → sel 00111, dest 6, reg2_o 0x44332211. Then BSH (hw1 0x3342) → reg2_o 0x22114433, sel 00110.
5. **Bcond:** BZ 0x05C2 at pc 0x10.
   - Z=1 → sel 00001, dest 0, reg1_o 0x10, reg2_o 8; REDIRECT, then fetch at `PC_i`=0x18.
   - Z=0 → sel 0, next fetch at 0x12.
6. **Suppression and illegal:** ADD to r0 (0x01C1) → sel 0, `illegal_o` 0. hw 0xFFFF → `illegal_o` pulses 1 cycle, pc+2. `rst_n`=0 while in FETCH1 → no issue, `imem_addr_o`=`RESET_PC` afterwards.
